obstacle_scheduler: RTL
=======================

// Module: obstacle_scheduler
// PURPOSE
//  Owns the three pipe obstacle slots: spawns pipes at a fixed frame interval, scrolls them left, retires them off-screen.
//  Assigns each new pipe a pseudo-random gap height.
//  Emits exactly one pass event per pipe when its right edge crosses the bird column; the score counter consumes it.
//  Sits between the frame timer and the renderer, collision and score logic; runs a global IDLE/RUN/HALT game FSM.
// PARAMETERS
//  SCREEN_W       640  visible width, pixels
//  OBS_WIDTH      60   pipe width, pixels; spawn right edge = SCREEN_W+OBS_WIDTH (fits 10 bits)
//  BIRD_X         160  bird column (BIRD_STARTING_DISTANCE); pass threshold
//  SPAWN_INTERVAL 90   frames between spawns, min 1
//  GAP_MIN        80   minimum gap-top y
//  GAP_BITS       7    gap_top = GAP_MIN + lfsr[GAP_BITS-1:0]
// PORTS
//  clk            in   1      system clock
//  reset          in   1      asynchronous, active-low reset (0 = reset)
//  frame_tick     in   1      one-cycle pulse per video frame
//  start          in   1      begin/restart game (level, sampled every clk)
//  done           in   1      collision/game-over from collision logic
//  speed          in   4      pixels scrolled per frame; 0 = freeze scroll
//  obs_right[3]   out  3x10   right-edge x of each slot
//  gap_top[3]     out  3x9    gap top y of each slot
//  obs_active     out  3      slot holds a live pipe
//  pass_valid     out  1      one-cycle pulse: ≥1 pipe passed bird this frame
//  pass_count     out  2      number of pipes passed, valid with pass_valid
//  game_state     out  2      IDLE=0, RUN=1, HALT=2
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; obs_active=0; obs_right=0; gap_top=0; pass_valid=0; pass_count=0.
//   Spawn counter=0; LFSR=16'hACE1. Reset mid-frame aborts everything; no pass pulse is issued.
//  FSM:
//   IDLE -start-> RUN (clears slots + spawn counter).
//   RUN -done-> HALT (done wins over start in the same cycle).
//   HALT -start&!done-> RUN (clears slots, counter).
//   IDLE ignores done.
//  Only RUN updates slots, on frame_tick; all updates registered, visible the cycle after the tick (latency 1).
//   Outside RUN, frame_tick is ignored and outputs hold (HALT freezes the final picture).
//  Per tick, per active slot i, in order:
//   1) Retire: if obs_right[i] <= speed, then obs_active[i]=0 and obs_right[i]=0 (no underflow wrap).
//   2) Else obs_right[i] -= speed.
//   3) Pass: if old >= BIRD_X and new < BIRD_X, slot counts toward pass_count.
//      A slot retiring while old >= BIRD_X also counts as a pass (speed jump).
//   Each pipe passes at most once: per-slot passed flag, cleared on spawn.
//  Spawn counter increments each RUN tick, saturating at SPAWN_INTERVAL.
//   At saturation, spawn into the lowest-index slot that is free after this tick's retires
//   (a same-tick retire frees the slot for reuse).
//   Spawn sets obs_right=SCREEN_W+OBS_WIDTH, gap_top=GAP_MIN+lfsr[GAP_BITS-1:0], then counter=0.
//   All slots busy: spawn deferred, counter holds saturated until a slot frees.
//  First spawn in a fresh RUN occurs on the SPAWN_INTERVAL-th tick.
//  pass_valid=1 for exactly one clk after a tick with pass_count>0; otherwise 0.
//  speed is sampled at the tick. All position arithmetic is 10-bit unsigned, compared before subtract.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk in all states; never all-zero.
// STRUCTURE
//  flappy_pkg: SCREEN_W, OBS_WIDTH, BIRD_STARTING_DISTANCE, NUM_OBS=3, typedef enum logic[1:0] game_state_t.
//  Sub-module lfsr16 (clk, reset, q[15:0]). Slot update is a generate loop over NUM_OBS.
//  Free-slot pick is a priority encoder.
// TESTING
//  1 Reset low mid-RUN with 2 active pipes -> all outputs 0 immediately (async), state IDLE.
//  2 start, speed=4, 90 ticks -> slot0 active, right=700. After 135 more ticks -> right=160, no pass yet.
//    Next tick -> right=156, pass_valid 1 clk, pass_count=1. No further pass from slot0.
//  3 speed=4, right=3 -> retire: active=0, right=0. Same tick spawn due -> slot0 reused, right=700.
//  4 SPAWN_INTERVAL=1, speed=0 -> slots fill 0,1,2. 4th spawn deferred; counter holds; no 4th pipe appears.
//  5 done and start same cycle in RUN -> HALT; frame_ticks change nothing.
//    start alone -> RUN, obs_active=0.
//  6 speed=15 with two pipes straddling BIRD_X same tick -> pass_count=2, single pass_valid pulse.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants and the game-state encoding for the flappy obstacle logic.
package flappy_pkg;
    localparam int SCREEN_W               = 640;
    localparam int OBS_WIDTH              = 60;
    localparam int BIRD_STARTING_DISTANCE = 160;
    localparam int NUM_OBS                = 3;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } game_state_t;
endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for pipe gap heights.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end
endmodule

// File: rtl/obstacle_scheduler.sv
// Pipe obstacle slots: timed spawning, per-frame scrolling, retirement and bird-pass events,
// governed by the IDLE/RUN/HALT game FSM.
module obstacle_scheduler
    import flappy_pkg::*;
#(
    parameter int SCREEN_W       = flappy_pkg::SCREEN_W,
    parameter int OBS_WIDTH      = flappy_pkg::OBS_WIDTH,
    parameter int BIRD_X         = BIRD_STARTING_DISTANCE,
    parameter int SPAWN_INTERVAL = 90,
    parameter int GAP_MIN        = 80,
    parameter int GAP_BITS       = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               done,
    input  logic [3:0]         speed,
    output logic [9:0]         obs_right [NUM_OBS],
    output logic [8:0]         gap_top [NUM_OBS],
    output logic [NUM_OBS-1:0] obs_active,
    output logic               pass_valid,
    output logic [1:0]         pass_count,
    output game_state_t        game_state
);
    localparam int               CNT_W       = $clog2(SPAWN_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(SPAWN_INTERVAL);
    localparam logic [9:0]       SPAWN_RIGHT = 10'(SCREEN_W + OBS_WIDTH);
    localparam logic [9:0]       PASS_X      = 10'(BIRD_X);
    localparam logic [8:0]       GAP_BASE    = 9'(GAP_MIN);
    localparam int               SEL_W       = $clog2(NUM_OBS);

    game_state_t        state, state_nxt;
    logic               run_tick, clear_slots;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;
    logic [CNT_W-1:0]   spawn_cnt, cnt_inc;
    logic               cnt_due, spawn_go, free_found;
    logic [SEL_W-1:0]   spawn_sel;
    logic [NUM_OBS-1:0] passed, retire, pass_hit, free_slot, spawn_here, nxt_act, nxt_passed;
    logic [9:0]         spd;
    logic [9:0]         moved [NUM_OBS];
    logic [9:0]         nxt_right [NUM_OBS];
    logic [8:0]         new_gap;
    logic [1:0]         pass_sum;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:GAP_BITS];
    assign new_gap     = GAP_BASE + 9'(lfsr_q[GAP_BITS-1:0]);
    assign spd         = {6'd0, speed};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // done has priority over start, so a simultaneous restart request cannot escape a game over
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (done) state_nxt = HALT;
            HALT:    if (start && !done) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        game_state  = state;
        run_tick    = (state == RUN) && frame_tick;
        clear_slots = (state != RUN) && (state_nxt == RUN);
    end

    assign cnt_inc  = (spawn_cnt == CNT_MAX) ? spawn_cnt : spawn_cnt + 1'b1;
    assign cnt_due  = (cnt_inc == CNT_MAX);
    assign spawn_go = run_tick && cnt_due && free_found;

    // Compare-before-subtract keeps the scroll from wrapping below zero
    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        assign retire[i]     = obs_active[i] && (obs_right[i] <= spd);
        assign moved[i]      = obs_right[i] - spd;
        assign pass_hit[i]   = obs_active[i] && !passed[i] && (obs_right[i] >= PASS_X)
                               && (retire[i] || (moved[i] < PASS_X));
        assign free_slot[i]  = !obs_active[i] || retire[i];
        assign spawn_here[i] = spawn_go && (spawn_sel == SEL_W'(i));
        assign nxt_act[i]    = spawn_here[i] || (obs_active[i] && !retire[i]);
        assign nxt_passed[i] = !spawn_here[i] && (passed[i] || pass_hit[i]);
        assign nxt_right[i]  = spawn_here[i] ? SPAWN_RIGHT :
                               (retire[i] || !obs_active[i]) ? 10'd0 : moved[i];
    end

    // Lowest-index free slot wins; a slot retiring on this tick already counts as free
    always_comb begin
        spawn_sel  = '0;
        free_found = 1'b0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (free_slot[i]) begin
                spawn_sel  = SEL_W'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        pass_sum = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            pass_sum = pass_sum + {1'b0, pass_hit[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obs_active <= '0;
            passed     <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                obs_right[i] <= '0;
                gap_top[i]   <= '0;
            end
        end else if (clear_slots) begin
            obs_active <= '0;
            passed     <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                obs_right[i] <= '0;
                gap_top[i]   <= '0;
            end
        end else if (run_tick) begin
            obs_active <= nxt_act;
            passed     <= nxt_passed;
            for (int i = 0; i < NUM_OBS; i++) begin
                obs_right[i] <= nxt_right[i];
                if (spawn_here[i]) gap_top[i] <= new_gap;
            end
        end
    end

    // A deferred spawn leaves the counter saturated so it fires as soon as a slot frees
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_cnt  <= '0;
            pass_valid <= 1'b0;
            pass_count <= '0;
        end else begin
            pass_valid <= run_tick && (pass_sum != 2'd0);
            pass_count <= run_tick ? pass_sum : 2'd0;
            if (clear_slots) begin
                spawn_cnt <= '0;
            end else if (run_tick) begin
                spawn_cnt <= spawn_go ? '0 : cnt_inc;
            end
        end
    end
endmodule
